// File: rtl/vj_stage_classifier.sv
// Viola-Jones cascade stage classifier.
// Accumulates signed per-feature votes for each cascade stage of one scan window,
// compares each stage sum against that stage's threshold, and reports whether the
// window survives every stage (face) or the index of the first stage that rejects it.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start, win_x, win_y         begin a new window (accepted only when idle)
//   feat_valid, feat_accum      feature vote stream; feat_ready is the handshake
//   stage_idx                   current stage, addresses the external weights table
//   stage_feat_count            beats expected for stage stage_idx (combinational lookup)
//   stage_threshold             pass threshold for stage stage_idx (combinational lookup)
//   busy                        window in progress
//   result_valid                one-cycle pulse; result_* fields valid and then held
//   result_face/x/y/stage       face flag, window coordinates, last stage evaluated
module vj_stage_classifier #(
    parameter int unsigned NUM_STAGES = 25,
    parameter int unsigned FEAT_CNT_W = 10,
    parameter int unsigned COORD_W    = 10,
    localparam int unsigned STAGE_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [COORD_W-1:0]    win_x,
    input  logic [COORD_W-1:0]    win_y,
    input  logic                  feat_valid,
    input  logic signed [31:0]    feat_accum,
    output logic                  feat_ready,
    output logic [STAGE_W-1:0]    stage_idx,
    input  logic [FEAT_CNT_W-1:0] stage_feat_count,
    input  logic signed [31:0]    stage_threshold,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  result_face,
    output logic [COORD_W-1:0]    result_x,
    output logic [COORD_W-1:0]    result_y,
    output logic [STAGE_W-1:0]    result_stage
);

    typedef enum logic [1:0] {StIdle, StAccum, StCheck, StDone} state_e;

    localparam logic [STAGE_W-1:0] LastStage = STAGE_W'(NUM_STAGES - 1);

    state_e                state_q, state_d;
    logic [STAGE_W-1:0]    stage_q, stage_d;
    logic signed [31:0]    sum_q, sum_d;
    logic [FEAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
    logic                  res_face_q, res_face_d;
    logic [COORD_W-1:0]    res_x_q, res_x_d, res_y_q, res_y_d;
    logic [STAGE_W-1:0]    res_stage_q, res_stage_d;

    logic                  beat_acc;
    logic [FEAT_CNT_W-1:0] cnt_inc;
    logic                  last_beat;
    logic                  stage_pass;
    logic                  last_stage;

    // Ready drops once the stage quota is met, which also covers a zero-count stage.
    assign feat_ready = (state_q == StAccum) && (cnt_q != stage_feat_count);
    assign beat_acc   = feat_valid && feat_ready;
    assign cnt_inc    = cnt_q + 1'b1;
    assign last_beat  = (cnt_inc == stage_feat_count);
    assign stage_pass = (sum_q >= stage_threshold);
    assign last_stage = (stage_q == LastStage);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            stage_q     <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            res_face_q  <= 1'b0;
            res_x_q     <= '0;
            res_y_q     <= '0;
            res_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_face_q  <= res_face_d;
            res_x_q     <= res_x_d;
            res_y_q     <= res_y_d;
            res_stage_q <= res_stage_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StAccum;
            StAccum: if ((stage_feat_count == '0) || (beat_acc && last_beat)) state_d = StCheck;
            StCheck: state_d = (stage_pass && !last_stage) ? StAccum : StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state; result fields load on the CHECK->DONE edge so they are
    // already valid during the result_valid cycle.
    always_comb begin
        stage_d     = stage_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        res_face_d  = res_face_q;
        res_x_d     = res_x_q;
        res_y_d     = res_y_q;
        res_stage_d = res_stage_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = win_x;
                    y_d     = win_y;
                    stage_d = '0;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            StAccum: begin
                if (beat_acc) begin
                    sum_d = sum_q + feat_accum;  // wraps modulo 2^32
                    cnt_d = cnt_inc;
                end
            end
            StCheck: begin
                if (stage_pass && !last_stage) begin
                    stage_d = stage_q + 1'b1;
                    sum_d   = '0;
                    cnt_d   = '0;
                end else begin
                    res_face_d  = stage_pass;
                    res_x_d     = x_q;
                    res_y_d     = y_q;
                    res_stage_d = stage_q;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy         = (state_q != StIdle);
        result_valid = (state_q == StDone);
        stage_idx    = stage_q;
        result_face  = res_face_q;
        result_x     = res_x_q;
        result_y     = res_y_q;
        result_stage = res_stage_q;
    end

endmodule

// File: doc/vj_stage_classifier.md
VJ_STAGE_CLASSIFIER -- requirements
Module: vj_stage_classifier

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 25: number of cascade stages per window.
REQ-002 SHALL have parameter FEAT_CNT_W, default 10: width of per-stage feature count and beat counter.
REQ-003 SHALL have parameter COORD_W, default 10: width of window x/y coordinates.
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-006 SHALL have port start, input, 1: begin classifying a new scan window.
REQ-007 SHALL have port win_x, input, COORD_W: window column, latched on accepted start.
REQ-008 SHALL have port win_y, input, COORD_W: window row, latched on accepted start.
REQ-009 SHALL have port feat_valid, input, 1: feat_accum beat valid.
REQ-010 SHALL have port feat_accum, input, 32, signed: per-feature vote from the accum_calculator stage.
REQ-011 SHALL have port feat_ready, output, 1: block can accept a feature beat.
REQ-012 SHALL have port stage_idx, output, $clog2(NUM_STAGES): current stage, drives the external weights lookup.
REQ-013 SHALL have port stage_feat_count, input, FEAT_CNT_W: feature count of stage stage_idx, combinational from lookup.
REQ-014 SHALL have port stage_threshold, input, 32, signed: threshold of stage stage_idx.
REQ-015 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-016 SHALL have port result_valid, output, 1: one-cycle pulse, result fields valid.
REQ-017 SHALL have outputs result_face (1), result_x/result_y (COORD_W), and result_stage (stage width): face flag, latched coordinates, and last stage evaluated.

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, CHECK, DONE.
REQ-019 IDLE: feat_ready=0; start=1 latches win_x/win_y, clears stage_idx, stage_sum and beat count, and goes to ACCUM.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 ACCUM: feat_ready=1; a beat is accepted when feat_valid&&feat_ready; each accepted beat adds feat_accum to stage_sum (32-bit signed, wrap on overflow) and increments the beat count.
REQ-022 ACCUM: the beat that makes the count equal stage_feat_count SHALL be accumulated, and the FSM SHALL enter CHECK next cycle with feat_ready=0 in CHECK.
REQ-023 ACCUM with stage_feat_count==0 SHALL accept no beat and go to CHECK next cycle with stage_sum=0.
REQ-024 feat_valid low in ACCUM SHALL stall without state change; there is no timeout.
REQ-025 CHECK, pass condition: signed stage_sum >= stage_threshold.
REQ-026 CHECK, fail: go to DONE with face=0 and result_stage=stage_idx.
REQ-027 CHECK, pass with stage_idx==NUM_STAGES-1: go to DONE with face=1 and result_stage=NUM_STAGES-1.
REQ-028 CHECK, pass otherwise: stage_idx+1, clear stage_sum and count, return to ACCUM.
REQ-029 DONE SHALL assert result_valid for exactly one cycle, update result_face/x/y/stage in that same cycle, then go to IDLE.
REQ-030 result_face/x/y/stage SHALL hold their values until the next DONE.
REQ-031 Latency SHALL be: start accepted at cycle 0, ACCUM from cycle 1, CHECK one cycle after the last beat of each stage, result_valid the cycle after the final CHECK.
REQ-032 A start asserted in the same cycle result_valid pulses SHALL be ignored; start is accepted from IDLE the following cycle.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE and clear stage_idx, stage_sum, count, feat_ready, busy, result_valid, result_face, result_x, result_y and result_stage to 0.
REQ-034 Reset mid-window SHALL discard the window with no result_valid pulse; beats presented during reset are dropped.

Verification
REQ-035 NUM_STAGES=2, counts {3,2}, thresholds {5,0}; start at x=4, y=7; beats 2,2,2 then 1,-1 back-to-back -> result_valid at cycle 8 with face=1, x=4, y=7, stage=1.
REQ-036 Same config with stage-0 beats 2,2,0 -> sum 4<5, result_valid at cycle 5 with face=0, stage=0, and no stage-1 beats accepted.
REQ-037 Beats -2147483648 and -1 with threshold 0 -> sum wraps to +2147483647, stage passes.
REQ-038 stage_feat_count=0 with threshold 0 -> no beats accepted, stage passes; with threshold 1 -> face=0.
REQ-039 rst_n low for 1 cycle after 2 of 3 beats -> IDLE, busy=0, no result_valid; a fresh start then completes normally.
REQ-040 Random feat_valid gaps plus start pulses while busy -> sums match a golden model, each extra start is ignored, and exactly one result_valid per accepted start.
